imem_loader: RTL

Writer side of the instruction memory. Owns a 512x8 byte store and fills it from an 8-bit valid/ready byte stream (boot/test loader). It also exposes the standard instruction-fetch read port: a 32-bit big-endian word assembled from 4 consecutive bytes. Program loading runs in hardware, at cycle level, in place of file preloading. The fetch stage reads through the read port once done has pulsed.

---
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader.sv | 106 ++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Loader bus: start/config, byte stream handshake, status and fetch read port.
interface imem_loader_if #(
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 10
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  load_len;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  byte_count;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       DataOut;

  modport master (
    output start, base_addr, load_len, in_valid, in_data, Address,
    input  in_ready, busy, done, byte_count, DataOut
  );

  modport slave (
    input  start, base_addr, load_len, in_valid, in_data, Address,
    output in_ready, busy, done, byte_count, DataOut
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory writer: fills a byte store from a valid/ready stream and
// serves 32-bit big-endian fetch words assembled from four consecutive bytes.
//
// state | meaning
// IDLE  | waiting for start; in_ready low
// LOAD  | accepting bytes into Mem[ptr], ptr wraps at DEPTH
// DONE  | one-cycle done pulse, then back to IDLE
module imem_loader #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  count_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              accept;

  logic [7:0]        mem [DEPTH];

  logic [ADDR_W-1:0] a0, a1, a2, a3;

  assign accept = (state == LOAD) && bus.in_valid;

  // Load sequencer with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      count_q   <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            ptr       <= bus.base_addr;
            // A zero length means a full-memory load.
            remaining <= (bus.load_len == '0) ? LEN_W'(DEPTH) : bus.load_len;
            count_q   <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            ptr       <= ptr + ADDR_W'(1);
            count_q   <= count_q + LEN_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Byte store write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[ptr] <= bus.in_data;
    end
  end

  // Fetch read: four consecutive bytes, addresses wrap naturally at ADDR_W.
  always_comb begin
    a0 = bus.Address;
    a1 = bus.Address + ADDR_W'(1);
    a2 = bus.Address + ADDR_W'(2);
    a3 = bus.Address + ADDR_W'(3);
  end

  assign bus.DataOut    = {mem[a0], mem[a1], mem[a2], mem[a3]};
  assign bus.in_ready   = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.byte_count = count_q;

endmodule
